// File: rtl/result_fifo_sink.sv
`default_nettype none
// ============================================================================
// Module      : result_fifo_sink
// Description : Collects {res1,res2} pairs from the arithmetic stage together
//               with their 34-bit sum into a show-ahead FIFO drained over a
//               valid/ready port. Counts pushes lost to overflow and turns
//               rising edges of the stage interrupt into a sticky flag plus
//               a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module result_fifo_sink #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,        // active-low, asynchronous
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [32:0]              res1,
    input  logic [32:0]              res2,
    input  logic                     intr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [32:0]              out_res1,
    output logic [32:0]              out_res2,
    output logic [33:0]              out_sum,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     intr_flag,
    input  logic                     intr_clr,
    output logic                     irq_pulse
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_ENTRY_W  = 100;
    localparam logic [c_PTR_W:0]   c_FULL_CNT = DEPTH[c_PTR_W:0];

    // Entry layout: {res1[32:0], res2[32:0], sum[33:0]}
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [CNT_W-1:0]     r_drop_cnt;
    logic                 r_popped;     // at least one entry has left since reset
    logic                 r_intr_d;
    logic                 r_irq_pulse;
    logic                 r_intr_flag;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_rise;
    logic [33:0]          w_sum;
    logic [c_PTR_W-1:0]   w_head_idx;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = ~w_empty & out_ready;
    assign w_drop  = in_valid & w_full;
    assign w_rise  = intr & ~r_intr_d;
    assign w_sum   = {1'b0, res1} + {1'b0, res2};

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {res1, res2, w_sum};
        end
    end

    // FIFO pointers, occupancy and overflow counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            r_popped   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_popped <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Interrupt edge detect: registered pulse and sticky flag (set beats clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_intr_d    <= 1'b0;
            r_irq_pulse <= 1'b0;
            r_intr_flag <= 1'b0;
        end else begin
            r_intr_d    <= intr;
            r_irq_pulse <= w_rise;
            r_intr_flag <= w_rise | (r_intr_flag & ~intr_clr);
        end
    end

    // Head selection. When empty, the slot just behind the read pointer still
    // holds the last popped entry (the next write lands at the read pointer),
    // so the outputs keep showing it; before any pop they read as zero.
    always_comb begin
        w_head_idx = r_rd_ptr;
        if (w_empty) begin
            w_head_idx = r_rd_ptr - 1'b1;
        end
        w_head = r_mem[w_head_idx];
        if (w_empty && !r_popped) begin
            w_head = '0;
        end
    end

    assign out_res1  = w_head[99:67];
    assign out_res2  = w_head[66:34];
    assign out_sum   = w_head[33:0];
    assign out_valid = ~w_empty;
    assign in_ready  = ~w_full;
    assign count     = r_count;
    assign drop_cnt  = r_drop_cnt;
    assign intr_flag = r_intr_flag;
    assign irq_pulse = r_irq_pulse;

endmodule
`default_nettype wire

// File: tb/tb_result_fifo_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_fifo_sink
// Description : Self-checking bench for result_fifo_sink. Accepted pushes are
//               queued in a scoreboard and compared when the DUT pops them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_fifo_sink;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] res1;
    logic [32:0] res2;
    logic        intr;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_res1;
    logic [32:0] out_res2;
    logic [33:0] out_sum;
    logic [3:0]  count;
    logic [15:0] drop_cnt;
    logic        intr_flag;
    logic        intr_clr;
    logic        irq_pulse;

    int checks = 0;
    int errors = 0;
    int m_count = 0;
    logic [99:0] sb [$];

    result_fifo_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res1      (res1),
        .res2      (res2),
        .intr      (intr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res1  (out_res1),
        .out_res2  (out_res2),
        .out_sum   (out_sum),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .intr_flag (intr_flag),
        .intr_clr  (intr_clr),
        .irq_pulse (irq_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus; queue the expected entry if the push is accepted.
    task automatic drive(input logic v, input logic [32:0] a, input logic [32:0] b,
                         input logic rdy);
        logic [33:0] s;
        int pu;
        int po;
        in_valid  = v;
        res1      = a;
        res2      = b;
        out_ready = rdy;
        s  = {1'b0, a} + {1'b0, b};
        pu = (v && (m_count < DEPTH)) ? 1 : 0;
        po = (rdy && (m_count > 0)) ? 1 : 0;
        if (pu == 1) sb.push_back({a, b, s});
        m_count = m_count + pu - po;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare the head on every cycle the DUT will pop it.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: DUT popped %h with nothing expected",
                         {out_res1, out_res2, out_sum});
            end else begin
                logic [99:0] exp;
                exp = sb.pop_front();
                if ({out_res1, out_res2, out_sum} !== exp) begin
                    errors++;
                    $display("FAIL head: got %h expected %h",
                             {out_res1, out_res2, out_sum}, exp);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; intr = 1'b0; intr_clr = 1'b0;
        res1 = '0; res2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({count, out_valid, in_ready, drop_cnt, intr_flag, irq_pulse} !==
            {4'd0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: cnt=%0d ov=%b ir=%b drop=%0d flag=%b pulse=%b",
                     count, out_valid, in_ready, drop_cnt, intr_flag, irq_pulse);
        end
        checks++;
        if ({out_res1, out_res2, out_sum} !== 100'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {out_res1, out_res2, out_sum});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        drive(1'b1, 33'd5, 33'd7, 1'b0);
        checks++;
        if ({out_valid, out_sum, count} !== {1'b1, 34'd12, 4'd1}) begin
            errors++;
            $display("FAIL basic_push: ov=%b sum=%0d cnt=%0d expected 1 12 1",
                     out_valid, out_sum, count);
        end
        drive(1'b0, 33'd0, 33'd0, 1'b1);
        checks++;
        if ({out_valid, count} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL basic_pop: ov=%b cnt=%0d expected 0 0", out_valid, count);
        end
        drive(1'b0, 33'd0, 33'd0, 1'b1);
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL empty_pop: cnt=%0d expected 0", count);
        end
    endtask

    task automatic test_wide_sum();
        drive(1'b1, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b0);
        checks++;
        if (out_sum !== 34'h3_FFFF_FFFE) begin
            errors++;
            $display("FAIL wide_sum: got %h expected 3fffffffe", out_sum);
        end
        drive(1'b0, 33'd0, 33'd0, 1'b1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 33'(i), 33'(i + 100), 1'b0);
        end
        checks++;
        if ({count, in_ready, drop_cnt} !== {4'd8, 1'b0, 16'd2}) begin
            errors++;
            $display("FAIL overflow: cnt=%0d ir=%b drop=%0d expected 8 0 2",
                     count, in_ready, drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 33'd0, 33'd0, 1'b1);
        end
        checks++;
        if ({count, out_valid} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL drain: cnt=%0d ov=%b expected 0 0", count, out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 33'(i + 50), 33'(i * 3), 1'b0);
        end
        drive(1'b1, 33'd99, 33'd1, 1'b1);
        checks++;
        if ({count, drop_cnt} !== {4'd7, 16'd3}) begin
            errors++;
            $display("FAIL full_push_pop: cnt=%0d drop=%0d expected 7 3", count, drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 33'd0, 33'd0, 1'b1);
        end
        checks++;
        if (count !== 4'd4) begin
            errors++;
            $display("FAIL b2b_start: cnt=%0d expected 4", count);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 33'(i * 7 + 1), 33'h1_0000_0000 + 33'(i), 1'b1);
            checks++;
            if (count !== 4'd4) begin
                errors++;
                $display("FAIL b2b_count[%0d]: cnt=%0d expected 4", i, count);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 33'd0, 33'd0, 1'b1);
        end
        checks++;
        if ((count !== 4'd0) || (sb.size() != 0)) begin
            errors++;
            $display("FAIL b2b_end: cnt=%0d leftover=%0d expected 0 0", count, sb.size());
        end
        drive(1'b0, 33'd0, 33'd0, 1'b0);
    endtask

    task automatic test_intr();
        int pulses;
        checks++;
        if ({intr_flag, irq_pulse} !== 2'b00) begin
            errors++;
            $display("FAIL intr_idle: flag=%b pulse=%b expected 0 0", intr_flag, irq_pulse);
        end
        intr = 1'b1;
        drive(1'b0, 33'd0, 33'd0, 1'b0);
        checks++;
        if ({intr_flag, irq_pulse} !== 2'b11) begin
            errors++;
            $display("FAIL intr_rise: flag=%b pulse=%b expected 1 1", intr_flag, irq_pulse);
        end
        pulses = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 33'd0, 33'd0, 1'b0);
            if (irq_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL intr_held: pulses=%0d expected 1", pulses);
        end
        intr = 1'b0;
        drive(1'b0, 33'd0, 33'd0, 1'b0);
        drive(1'b0, 33'd0, 33'd0, 1'b0);
        intr = 1'b1;
        intr_clr = 1'b1;
        drive(1'b0, 33'd0, 33'd0, 1'b0);
        checks++;
        if ({intr_flag, irq_pulse} !== 2'b11) begin
            errors++;
            $display("FAIL set_beats_clr: flag=%b pulse=%b expected 1 1", intr_flag, irq_pulse);
        end
        intr_clr = 1'b0;
        drive(1'b0, 33'd0, 33'd0, 1'b0);
        intr_clr = 1'b1;
        drive(1'b0, 33'd0, 33'd0, 1'b0);
        checks++;
        if ({intr_flag, irq_pulse} !== 2'b00) begin
            errors++;
            $display("FAIL intr_clr: flag=%b pulse=%b expected 0 0", intr_flag, irq_pulse);
        end
        intr_clr = 1'b0;
        intr = 1'b0;
        drive(1'b0, 33'd0, 33'd0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 33'(i + 200), 33'(i), 1'b0);
        end
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d expected 5", count);
        end
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({count, out_valid, drop_cnt, in_ready} !== {4'd0, 1'b0, 16'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d ov=%b drop=%0d ir=%b expected 0 0 0 1",
                     count, out_valid, drop_cnt, in_ready);
        end
        sb.delete();
        m_count = 0;
        intr = 1'b1;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({irq_pulse, intr_flag, out_valid} !== 3'b110) begin
            errors++;
            $display("FAIL post_reset_intr: pulse=%b flag=%b ov=%b expected 1 1 0",
                     irq_pulse, intr_flag, out_valid);
        end
        intr = 1'b0;
        drive(1'b0, 33'd0, 33'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wide_sum();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_intr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
